// File: rtl/w_bit_n_mux_pkg.sv
// Shared constants and helpers for the registered W-bit N-way multiplexer.
package w_bit_n_mux_pkg;

  localparam int unsigned MAX_N = 4;
  localparam int unsigned MAX_M = 2;
  localparam int unsigned MAX_W = 64;

  // Minimum select width (ceil log2, at least 1) needed to address n inputs.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/w_bit_n_mux_if.sv
// Data/select bus between the word sources and the registered multiplexer.
interface w_bit_n_mux_if #(
  parameter int unsigned W = 4,
  parameter int unsigned m = 2
);
  logic [W-1:0] a3;
  logic [W-1:0] a2;
  logic [W-1:0] a1;
  logic [W-1:0] a0;
  logic [m-1:0] sel;
  logic [W-1:0] out;

  modport master (output a3, a2, a1, a0, sel, input out);
  modport slave  (input a3, a2, a1, a0, sel, output out);
endinterface

// File: rtl/w_bit_n_mux_comb.sv
// Combinational N-way word selector; unused or out-of-range selects yield zero.
module w_bit_n_mux_comb
  import w_bit_n_mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned m = 2,
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a3,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a0,
  input  logic [m-1:0] sel,
  output logic [W-1:0] out_c
);

  logic [MAX_M-1:0] sel_ext;

  assign sel_ext = MAX_M'(sel);

  // Inputs at or above N are masked so they can never reach the output.
  always_comb begin
    out_c = '0;
    case (sel_ext)
      2'd0:    out_c = a0;
      2'd1:    out_c = a1;
      2'd2:    out_c = (N > 2) ? a2 : '0;
      2'd3:    out_c = (N > 3) ? a3 : '0;
      default: out_c = '0;
    endcase
  end

endmodule

// File: rtl/w_bit_n_mux.sv
// Registered W-bit N-way multiplexer: out is the selected word one clock later.
module w_bit_n_mux
  import w_bit_n_mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned m = 2,
  parameter int unsigned W = 4
) (
  input  logic            clk,
  input  logic            rst,
  w_bit_n_mux_if.slave    bus
);

  if (N < 32'd2 || N > MAX_N) begin : g_bad_n
    $error("w_bit_n_mux: N=%0d outside 2..%0d", N, MAX_N);
  end
  if (m < sel_width(N) || m > MAX_M) begin : g_bad_m
    $error("w_bit_n_mux: m=%0d cannot address N=%0d inputs", m, N);
  end
  if (W < 32'd1 || W > MAX_W) begin : g_bad_w
    $error("w_bit_n_mux: W=%0d outside 1..%0d", W, MAX_W);
  end

  logic [W-1:0] sel_c;
  logic [W-1:0] out_d;
  logic [W-1:0] out_q;

  w_bit_n_mux_comb #(
    .N (N),
    .m (m),
    .W (W)
  ) u_comb (
    .a3    (bus.a3),
    .a2    (bus.a2),
    .a1    (bus.a1),
    .a0    (bus.a0),
    .sel   (bus.sel),
    .out_c (sel_c)
  );

  // Reset wins over the pending selection.
  always_comb begin
    out_d = sel_c;
    if (rst) out_d = '0;
  end

  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_w_bit_n_mux.sv
// Directed bench for w_bit_n_mux: a 4-way instance and a 3-way instance.
module tb_w_bit_n_mux;
  import w_bit_n_mux_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  w_bit_n_mux_if #(.W(4), .m(2)) bus4 ();
  w_bit_n_mux_if #(.W(4), .m(2)) bus3 ();

  w_bit_n_mux #(.N(4), .m(2), .W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  w_bit_n_mux #(.N(3), .m(2), .W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive4(input logic [1:0] s, input logic [3:0] d3, input logic [3:0] d2,
                        input logic [3:0] d1, input logic [3:0] d0);
    bus4.sel = s; bus4.a3 = d3; bus4.a2 = d2; bus4.a1 = d1; bus4.a0 = d0;
  endtask

  task automatic drive3(input logic [1:0] s, input logic [3:0] d3, input logic [3:0] d2,
                        input logic [3:0] d1, input logic [3:0] d0);
    bus3.sel = s; bus3.a3 = d3; bus3.a2 = d2; bus3.a1 = d1; bus3.a0 = d0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive4(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
    drive3(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
    step();
    checks++;
    if (bus4.out !== 4'b0000) begin
      errors++; $display("FAIL reset_edge1 got %b exp %b", bus4.out, 4'b0000);
    end
    step();
    checks++;
    if (bus4.out !== 4'b0000) begin
      errors++; $display("FAIL reset_edge2 got %b exp %b", bus4.out, 4'b0000);
    end
    checks++;
    if (bus3.out !== 4'b0000) begin
      errors++; $display("FAIL reset_n3 got %b exp %b", bus3.out, 4'b0000);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus4.out !== 4'b0101) begin
      errors++; $display("FAIL reset_release got %b exp %b", bus4.out, 4'b0101);
    end
  endtask

  task automatic test_select_a0();
    drive4(2'b00, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    step();
    checks++;
    if (bus4.out !== 4'b0000) begin
      errors++; $display("FAIL sel0_a1_ignored got %b exp %b", bus4.out, 4'b0000);
    end
    drive4(2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    step();
    checks++;
    if (bus4.out !== 4'b0000) begin
      errors++; $display("FAIL sel0_a3_ignored got %b exp %b", bus4.out, 4'b0000);
    end
    drive4(2'b00, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    step();
    checks++;
    if (bus4.out !== 4'b0001) begin
      errors++; $display("FAIL sel0_a0 got %b exp %b", bus4.out, 4'b0001);
    end
  endtask

  task automatic test_select_mixed();
    drive4(2'b10, 4'b0101, 4'b0100, 4'b0100, 4'b0100);
    step();
    checks++;
    if (bus4.out !== 4'b0100) begin
      errors++; $display("FAIL sel2 got %b exp %b", bus4.out, 4'b0100);
    end
    drive4(2'b11, 4'b0001, 4'b1000, 4'b0000, 4'b1000);
    step();
    checks++;
    if (bus4.out !== 4'b0001) begin
      errors++; $display("FAIL sel3 got %b exp %b", bus4.out, 4'b0001);
    end
    drive4(2'b01, 4'b1100, 4'b1010, 4'b0110, 4'b0011);
    step();
    checks++;
    if (bus4.out !== 4'b0110) begin
      errors++; $display("FAIL sel1 got %b exp %b", bus4.out, 4'b0110);
    end
  endtask

  task automatic test_held();
    step();
    checks++;
    if (bus4.out !== 4'b0110) begin
      errors++; $display("FAIL held_1 got %b exp %b", bus4.out, 4'b0110);
    end
    step();
    checks++;
    if (bus4.out !== 4'b0110) begin
      errors++; $display("FAIL held_2 got %b exp %b", bus4.out, 4'b0110);
    end
  endtask

  task automatic test_latency();
    drive4(2'b10, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    step();
    checks++;
    if (bus4.out !== 4'b0100) begin
      errors++; $display("FAIL lat_load got %b exp %b", bus4.out, 4'b0100);
    end
    #2 bus4.a2 = 4'b1111;
    #1;
    checks++;
    if (bus4.out !== 4'b0100) begin
      errors++; $display("FAIL lat_midcycle got %b exp %b", bus4.out, 4'b0100);
    end
    step();
    checks++;
    if (bus4.out !== 4'b1111) begin
      errors++; $display("FAIL lat_next_edge got %b exp %b", bus4.out, 4'b1111);
    end
  endtask

  task automatic test_reset_midstream();
    drive4(2'b10, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    step();
    checks++;
    if (bus4.out !== 4'b0100) begin
      errors++; $display("FAIL rstmid_load got %b exp %b", bus4.out, 4'b0100);
    end
    #2 bus4.a2 = 4'b1111;
    rst = 1'b1;
    #1;
    checks++;
    if (bus4.out !== 4'b0100) begin
      errors++; $display("FAIL rstmid_hold got %b exp %b", bus4.out, 4'b0100);
    end
    step();
    checks++;
    if (bus4.out !== 4'b0000) begin
      errors++; $display("FAIL rstmid_clear got %b exp %b", bus4.out, 4'b0000);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus4.out !== 4'b1111) begin
      errors++; $display("FAIL rstmid_resume got %b exp %b", bus4.out, 4'b1111);
    end
  endtask

  task automatic test_out_of_range();
    drive3(2'b11, 4'b1111, 4'b0001, 4'b0001, 4'b0001);
    step();
    checks++;
    if (bus3.out !== 4'b0000) begin
      errors++; $display("FAIL n3_sel3_zero got %b exp %b", bus3.out, 4'b0000);
    end
    drive3(2'b10, 4'b1111, 4'b0010, 4'b0001, 4'b0100);
    step();
    checks++;
    if (bus3.out !== 4'b0010) begin
      errors++; $display("FAIL n3_sel2 got %b exp %b", bus3.out, 4'b0010);
    end
    drive3(2'b00, 4'b1111, 4'b0010, 4'b0001, 4'b0100);
    step();
    checks++;
    if (bus3.out !== 4'b0100) begin
      errors++; $display("FAIL n3_sel0 got %b exp %b", bus3.out, 4'b0100);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive4(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drive3(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    #1;
    test_reset();
    test_select_a0();
    test_select_mixed();
    test_held();
    test_latency();
    test_reset_midstream();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
